pzcorebus_bundled_csr_master: RTL and testbench

Single-outstanding corebus master that turns a simple valid/ready register-access request into one corebus command: READ, or WRITE_NON_POSTED plus one data beat. It returns the corebus response, or a local timeout, on a result port. It drives the master end of a `pzcorebus_bundled_if`. Use it wherever a control FSM or debug port must reach a corebus slave without a full DMA engine.

---
 rtl/pzcorebus_csr_master_pkg.sv | 22 ++
 rtl/pzcorebus_pkg.sv | 34 +++
 rtl/pzcorebus_bundled_if.sv | 58 +++++
 rtl/pzcorebus_bundled_csr_master.sv | 174 +++++++++++++++++
 tb/tb_pzcorebus_bundled_csr_master.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pzcorebus_csr_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pzcorebus_csr_master_pkg                                                 |
// | FSM encoding and timeout-counter sizing for the bundled CSR master.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pzcorebus_csr_master_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'd0,
    STATE_ISSUE     = 2'd1,
    STATE_WAIT_RESP = 2'd2,
    STATE_DONE      = 2'd3
  } csr_master_state_e;

  // A disabled timeout (0 cycles) still needs a one-bit counter to exist
  function automatic int timeout_counter_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pzcorebus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pzcorebus_pkg                                                            |
// | Bus configuration record and command encodings shared by corebus blocks. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pzcorebus_pkg;

  // Field widths of one corebus instance
  typedef struct packed {
    int address_width;
    int data_width;
    int id_width;
    int length_width;
    int info_width;
  } pzcorebus_config;

  localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
    address_width: 32,
    data_width:    32,
    id_width:      4,
    length_width:  4,
    info_width:    2
  };

  typedef enum logic [3:0] {
    PZCOREBUS_NULL_COMMAND     = 4'h0,
    PZCOREBUS_READ             = 4'h4,
    PZCOREBUS_WRITE            = 4'h8,
    PZCOREBUS_WRITE_NON_POSTED = 4'h9
  } pzcorebus_command_type;

endpackage
`default_nettype wire

// File: rtl/pzcorebus_bundled_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pzcorebus_bundled_if                                                     |
// | Command, write-data and response channels of one corebus link.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pzcorebus_bundled_if
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = PZCOREBUS_DEFAULT_CONFIG
);
  localparam int ADDRESS_WIDTH = BUS_CONFIG.address_width;
  localparam int DATA_WIDTH    = BUS_CONFIG.data_width;
  localparam int ID_WIDTH      = BUS_CONFIG.id_width;
  localparam int LENGTH_WIDTH  = BUS_CONFIG.length_width;
  localparam int INFO_WIDTH    = BUS_CONFIG.info_width;

  logic                        mcmd_valid;
  logic                        mcmd_accept;
  pzcorebus_command_type       mcmd_command;
  logic [ID_WIDTH-1:0]         mcmd_id;
  logic [ADDRESS_WIDTH-1:0]    mcmd_address;
  logic [LENGTH_WIDTH-1:0]     mcmd_length;
  logic [INFO_WIDTH-1:0]       mcmd_info;

  logic                        mdata_valid;
  logic                        mdata_accept;
  logic [DATA_WIDTH-1:0]       mdata;
  logic [DATA_WIDTH/8-1:0]     mdata_byte_enable;
  logic                        mdata_last;

  logic                        sresp_valid;
  logic                        mresp_accept;
  logic [ID_WIDTH-1:0]         sresp_id;
  logic                        sresp_error;
  logic [DATA_WIDTH-1:0]       sresp_data;
  logic                        sresp_last;

  modport master (
    output mcmd_valid, input mcmd_accept, output mcmd_command, output mcmd_id,
    output mcmd_address, output mcmd_length, output mcmd_info,
    output mdata_valid, input mdata_accept, output mdata, output mdata_byte_enable,
    output mdata_last,
    input sresp_valid, output mresp_accept, input sresp_id, input sresp_error,
    input sresp_data, input sresp_last
  );

  modport slave (
    input mcmd_valid, output mcmd_accept, input mcmd_command, input mcmd_id,
    input mcmd_address, input mcmd_length, input mcmd_info,
    input mdata_valid, output mdata_accept, input mdata, input mdata_byte_enable,
    input mdata_last,
    output sresp_valid, input mresp_accept, output sresp_id, output sresp_error,
    output sresp_data, output sresp_last
  );

endinterface
`default_nettype wire

// File: rtl/pzcorebus_bundled_csr_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pzcorebus_bundled_csr_master                                             |
// | Single-outstanding register-access master: one request becomes a READ   |
// | or WRITE_NON_POSTED command, the response (or a timeout) is returned.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pzcorebus_bundled_csr_master
  import pzcorebus_pkg::*;
  import pzcorebus_csr_master_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG     = PZCOREBUS_DEFAULT_CONFIG,
  parameter int unsigned     ID             = 0,
  parameter int unsigned     TIMEOUT_CYCLES = 1024
)(
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_req_valid,
  output logic                                o_req_ready,
  input  logic                                i_req_write,
  input  logic [BUS_CONFIG.address_width-1:0] i_req_address,
  input  logic [BUS_CONFIG.data_width-1:0]    i_req_data,
  input  logic [BUS_CONFIG.data_width/8-1:0]  i_req_byte_enable,
  output logic                                o_result_valid,
  output logic [BUS_CONFIG.data_width-1:0]    o_result_data,
  output logic                                o_result_error,
  output logic                                o_result_timeout,
  pzcorebus_bundled_if.master                 master_if
);
  localparam int ADDRESS_WIDTH = BUS_CONFIG.address_width;
  localparam int DATA_WIDTH    = BUS_CONFIG.data_width;
  localparam int ID_WIDTH      = BUS_CONFIG.id_width;
  localparam int LENGTH_WIDTH  = BUS_CONFIG.length_width;

  localparam logic [ID_WIDTH-1:0] ID_VALUE       = ID_WIDTH'(ID);
  localparam int                  TIMER_WIDTH    = timeout_counter_width(TIMEOUT_CYCLES);
  localparam bit                  TIMEOUT_ENABLE = (TIMEOUT_CYCLES != 0);
  // The counter starts at 0 on WAIT_RESP entry, so TIMEOUT_CYCLES waiting
  // cycles have elapsed when it holds TIMEOUT_CYCLES-1 at a clock edge.
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMER_WIDTH'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = {TIMER_WIDTH{1'b1}};

  csr_master_state_e            state;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDRESS_WIDTH-1:0]     req_address;
  logic [DATA_WIDTH-1:0]        req_data;
  logic [DATA_WIDTH/8-1:0]      req_byte_enable;
  pzcorebus_command_type        cmd_type;
  logic [ID_WIDTH-1:0]          cmd_id;
  logic [LENGTH_WIDTH-1:0]      cmd_length;
  logic                         data_last;
  logic                         mcmd_valid;
  logic                         mdata_valid;
  logic                         resp_accept;
  logic [TIMER_WIDTH-1:0]       timer;
  logic                         result_valid;
  logic [DATA_WIDTH-1:0]        result_data;
  logic                         result_error;
  logic                         result_timeout;

  logic                         cmd_taken;
  logic                         data_taken;
  logic                         resp_hit;

  // A channel counts as done once its valid has dropped or it is accepted now
  assign cmd_taken  = !mcmd_valid  || master_if.mcmd_accept;
  assign data_taken = !mdata_valid || master_if.mdata_accept;
  assign resp_hit   = resp_accept && master_if.sresp_valid &&
                      (master_if.sresp_id == ID_VALUE) && master_if.sresp_last;

  // Request capture, command/data issue, response wait and result generation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= STATE_IDLE;
      req_ready       <= 1'b1;
      req_write       <= 1'b0;
      req_address     <= '0;
      req_data        <= '0;
      req_byte_enable <= '0;
      cmd_type        <= PZCOREBUS_NULL_COMMAND;
      cmd_id          <= '0;
      cmd_length      <= '0;
      data_last       <= 1'b0;
      mcmd_valid      <= 1'b0;
      mdata_valid     <= 1'b0;
      resp_accept     <= 1'b1;
      timer           <= '0;
      result_valid    <= 1'b0;
      result_data     <= '0;
      result_error    <= 1'b0;
      result_timeout  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (i_req_valid && req_ready) begin
            req_write       <= i_req_write;
            req_address     <= i_req_address;
            req_data        <= i_req_data;
            req_byte_enable <= i_req_byte_enable;
            cmd_type        <= i_req_write ? PZCOREBUS_WRITE_NON_POSTED : PZCOREBUS_READ;
            cmd_id          <= ID_VALUE;
            cmd_length      <= LENGTH_WIDTH'(1);
            data_last       <= 1'b1;
            mcmd_valid      <= 1'b1;
            mdata_valid     <= i_req_write;
            req_ready       <= 1'b0;
            resp_accept     <= 1'b0;
            state           <= STATE_ISSUE;
          end
        end
        STATE_ISSUE: begin
          if (master_if.mcmd_accept) begin
            mcmd_valid <= 1'b0;
          end
          if (master_if.mdata_accept) begin
            mdata_valid <= 1'b0;
          end
          if (cmd_taken && data_taken) begin
            resp_accept <= 1'b1;
            timer       <= '0;
            state       <= STATE_WAIT_RESP;
          end
        end
        STATE_WAIT_RESP: begin
          if (resp_hit) begin
            result_data    <= req_write ? '0 : master_if.sresp_data;
            result_error   <= master_if.sresp_error;
            result_timeout <= 1'b0;
            result_valid   <= 1'b1;
            state          <= STATE_DONE;
          end else if (TIMEOUT_ENABLE && (timer == TIMER_LAST)) begin
            result_data    <= '0;
            result_error   <= 1'b1;
            result_timeout <= 1'b1;
            result_valid   <= 1'b1;
            state          <= STATE_DONE;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end
        STATE_DONE: begin
          req_ready <= 1'b1;
          state     <= STATE_IDLE;
        end
        default: begin
          state <= STATE_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready      = req_ready;
  assign o_result_valid   = result_valid;
  assign o_result_data    = result_data;
  assign o_result_error   = result_error;
  assign o_result_timeout = result_timeout;

  assign master_if.mcmd_valid        = mcmd_valid;
  assign master_if.mcmd_command      = cmd_type;
  assign master_if.mcmd_id           = cmd_id;
  assign master_if.mcmd_address      = req_address;
  assign master_if.mcmd_length       = cmd_length;
  assign master_if.mcmd_info         = '0;
  assign master_if.mdata_valid       = mdata_valid;
  assign master_if.mdata             = req_data;
  assign master_if.mdata_byte_enable = req_byte_enable;
  assign master_if.mdata_last        = data_last;
  assign master_if.mresp_accept      = resp_accept;

endmodule
`default_nettype wire

// File: tb/tb_pzcorebus_bundled_csr_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pzcorebus_bundled_csr_master                                          |
// | Scoreboard bench: a bus-slave driver issues requests and responses, a    |
// | separate monitor checks every result pulse against queued expectations.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pzcorebus_bundled_csr_master;
  import pzcorebus_pkg::*;

  localparam pzcorebus_config CFG = '{
    address_width: 32, data_width: 32, id_width: 4, length_width: 4, info_width: 2
  };
  localparam int unsigned ID      = 5;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_byte_enable = '0;
  logic        result_valid;
  logic [31:0] result_data;
  logic        result_error;
  logic        result_timeout;

  pzcorebus_bundled_if #(.BUS_CONFIG(CFG)) bus ();

  pzcorebus_bundled_csr_master #(
    .BUS_CONFIG     (CFG),
    .ID             (ID),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_write       (req_write),
    .i_req_address     (req_address),
    .i_req_data        (req_data),
    .i_req_byte_enable (req_byte_enable),
    .o_result_valid    (result_valid),
    .o_result_data     (result_data),
    .o_result_error    (result_error),
    .o_result_timeout  (result_timeout),
    .master_if         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (rst_n && result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got data=%0h err=%0b to=%0b want none",
                 result_data, result_error, result_timeout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_data", result_data, e.data);
        chk("result_error", 32'(result_error), 32'(e.err));
        chk("result_timeout", 32'(result_timeout), 32'(e.to));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_mcmd_valid"}, 32'(bus.mcmd_valid), 32'd0);
    chk({tag, "_mcmd_command"}, 32'(bus.mcmd_command), 32'd0);
    chk({tag, "_mcmd_id"}, 32'(bus.mcmd_id), 32'd0);
    chk({tag, "_mcmd_address"}, bus.mcmd_address, 32'd0);
    chk({tag, "_mcmd_length"}, 32'(bus.mcmd_length), 32'd0);
    chk({tag, "_mdata_valid"}, 32'(bus.mdata_valid), 32'd0);
    chk({tag, "_mdata"}, bus.mdata, 32'd0);
    chk({tag, "_mdata_last"}, 32'(bus.mdata_last), 32'd0);
    chk({tag, "_mresp_accept"}, 32'(bus.mresp_accept), 32'd1);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_result_data"}, result_data, 32'd0);
    chk({tag, "_result_error"}, 32'(result_error), 32'd0);
    chk({tag, "_result_timeout"}, 32'(result_timeout), 32'd0);
  endtask

  task automatic drive_resp(input logic [3:0] id, input logic [31:0] data, input logic err);
    bus.sresp_valid = 1'b1;
    bus.sresp_id    = id;
    bus.sresp_data  = data;
    bus.sresp_error = err;
    bus.sresp_last  = 1'b1;
  endtask

  // One request: cycle j counts clock periods after the final issue accept.
  task automatic run_tx(
    input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
    input int cmd_delay, input int data_delay, input bit no_resp, input int resp_cycle,
    input int stray_cycle, input int late_cycle, input logic [31:0] rdata, input bit rerr,
    input int reset_cycle
  );
    exp_t e;
    int   exp_cycle;
    bit   cmd_done;
    bit   data_done;
    int   k;
    logic [3:0] wrong_id;
    if (reset_cycle == 0) begin
      e.data = (wr || no_resp) ? 32'd0 : rdata;
      e.err  = no_resp ? 1'b1 : rerr;
      e.to   = no_resp;
      sb.push_back(e);
    end
    exp_cycle = no_resp ? int'(TIMEOUT) + 1 : resp_cycle + 1;

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid       = 1'b1;
    req_write       = wr;
    req_address     = addr;
    req_data        = wdata;
    req_byte_enable = be;
    @(posedge clk);

    cmd_done  = 1'b0;
    data_done = !wr;
    k = 0;
    while (!(cmd_done && data_done)) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid       = 1'b0;
        req_write       = 1'($urandom);
        req_address     = $urandom;
        req_data        = $urandom;
        req_byte_enable = 4'($urandom);
      end
      if (k >= 40) begin
        bad++;
        $display("FAIL issue_bound: got no accept exit after %0d cycles want exit", k);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "issue phase stuck");
      end
      chk("req_ready_issue", 32'(req_ready), 32'd0);
      chk("mresp_accept_issue", 32'(bus.mresp_accept), 32'd0);
      if (cmd_done) begin
        chk("mcmd_valid_drop", 32'(bus.mcmd_valid), 32'd0);
      end else begin
        chk("mcmd_valid", 32'(bus.mcmd_valid), 32'd1);
        chk("mcmd_command", 32'(bus.mcmd_command),
            32'(wr ? PZCOREBUS_WRITE_NON_POSTED : PZCOREBUS_READ));
        chk("mcmd_id", 32'(bus.mcmd_id), ID);
        chk("mcmd_address", bus.mcmd_address, addr);
        chk("mcmd_length", 32'(bus.mcmd_length), 32'd1);
        chk("mcmd_info", 32'(bus.mcmd_info), 32'd0);
      end
      if (!wr) begin
        chk("mdata_valid_read", 32'(bus.mdata_valid), 32'd0);
      end else if (data_done) begin
        chk("mdata_valid_drop", 32'(bus.mdata_valid), 32'd0);
      end else begin
        chk("mdata_valid", 32'(bus.mdata_valid), 32'd1);
        chk("mdata", bus.mdata, wdata);
        chk("mdata_byte_enable", 32'(bus.mdata_byte_enable), 32'(be));
        chk("mdata_last", 32'(bus.mdata_last), 32'd1);
      end
      bus.mcmd_accept  = !cmd_done && (k >= cmd_delay);
      bus.mdata_accept = wr && !data_done && (k >= data_delay);
      @(posedge clk);
      if (bus.mcmd_accept) cmd_done = 1'b1;
      if (bus.mdata_accept) data_done = 1'b1;
      k++;
    end

    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.mcmd_accept  = 1'b0;
        bus.mdata_accept = 1'b0;
      end
      if (reset_cycle != 0 && j == reset_cycle) begin
        bus.sresp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midreset_hold");
        rst_n = 1'b1;
        return;
      end
      chk("result_valid_timing", 32'(result_valid), 32'(j == exp_cycle));
      chk("req_ready_wait", 32'(req_ready), 32'(j > exp_cycle));
      chk("mresp_accept_wait", 32'(bus.mresp_accept), 32'd1);
      bus.sresp_valid = 1'b0;
      if (!no_resp && j == resp_cycle) begin
        drive_resp(4'(ID), rdata, rerr);
      end else if (stray_cycle != 0 && j == stray_cycle) begin
        wrong_id = 4'(ID) ^ 4'($urandom_range(1, 15));
        drive_resp(wrong_id, $urandom, 1'($urandom));
      end else if (no_resp && j == late_cycle) begin
        drive_resp(4'(ID), $urandom, 1'($urandom));
      end
    end
    bus.sresp_valid = 1'b0;
  endtask

  bit   r_wr;
  bit   r_nr;
  int   r_rc;
  int   r_sc;

  initial begin
    bus.mcmd_accept  = 1'b0;
    bus.mdata_accept = 1'b0;
    bus.sresp_valid  = 1'b0;
    bus.sresp_id     = '0;
    bus.sresp_error  = 1'b0;
    bus.sresp_data   = '0;
    bus.sresp_last   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Read, immediate accept, response on the first waiting cycle
    run_tx(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 1'b0, 1, 0, 0, 32'h1234_5678, 1'b0, 0);
    // Write, byte enables 0x3, data accepted three cycles after the command
    run_tx(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'h3, 0, 3, 1'b0, 2, 0, 0, 32'hFFFF_FFFF, 1'b0, 0);
    // Read returning an error
    run_tx(1'b0, 32'h0000_0308, 32'h0, 4'h0, 1, 0, 1'b0, 3, 0, 0, 32'hDEAD_BEEF, 1'b1, 0);
    // No response: timeout, then a late response drained in IDLE
    run_tx(1'b0, 32'h0000_040C, 32'h0, 4'h0, 0, 0, 1'b1, 0, 0, 10, 32'h0, 1'b0, 0);
    // Timeout with the late response landing in DONE
    run_tx(1'b1, 32'h0000_0410, 32'h1111_2222, 4'hF, 2, 1, 1'b1, 0, 0, 9, 32'h0, 1'b0, 0);
    // Stray wrong-ID response ahead of the real one
    run_tx(1'b0, 32'h0000_0510, 32'h0, 4'h0, 0, 0, 1'b0, 4, 2, 0, 32'h0BAD_F00D, 1'b0, 0);
    // Matching response in the expiry cycle beats the timeout
    run_tx(1'b0, 32'h0000_0614, 32'h0, 4'h0, 0, 0, 1'b0, int'(TIMEOUT), 0, 0, 32'h55AA_55AA, 1'b0, 0);
    // Reset pulsed while waiting for the response
    run_tx(1'b1, 32'h0000_0718, 32'h3333_4444, 4'h5, 0, 0, 1'b0, 5, 0, 0, 32'h0, 1'b0, 2);
    // Normal completion right after that reset
    run_tx(1'b0, 32'h0000_081C, 32'h0, 4'h0, 0, 0, 1'b0, 2, 0, 0, 32'hA5A5_0F0F, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_nr = ($urandom_range(0, 5) == 0);
      r_rc = $urandom_range(1, int'(TIMEOUT));
      r_sc = (r_rc >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, r_rc - 1) : 0;
      run_tx(r_wr, $urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             r_nr, r_rc, r_sc, $urandom_range(9, 10), $urandom, ($urandom_range(0, 3) == 0), 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
